// File: rtl/player_motion_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : player_motion_ctrl
// Description : Two-player horizontal motion controller with knockback.
//               Advances both X positions once per frame_tick from each
//               player's movement FSM code, applies knockback after a hit,
//               clamps to the walls and keeps the players at least MIN_SEP
//               apart.
// Ports       : clk, reset_n (sync, active low), frame_tick (update strobe),
//               p1_state/p2_state (1=FORWARD, 2=BACKWARD, else hold),
//               p1_hit/p2_hit (start knockback),
//               p1_x/p2_x (registered positions),
//               p1_kb_active/p2_kb_active (registered knockback flags),
//               p1_at_wall/p2_at_wall, contact (decoded from positions).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module player_motion_ctrl #(
    parameter int POS_W     = 10,
    parameter int CHAR_W    = 64,
    parameter int MAP_W     = 640,
    parameter int FWD_STEP  = 3,
    parameter int BWD_STEP  = 2,
    parameter int KB_STEP   = 4,
    parameter int KB_FRAMES = 8,
    parameter int MIN_SEP   = 2 * CHAR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic [3:0]       p1_state,
    input  logic [3:0]       p2_state,
    input  logic             p1_hit,
    input  logic             p2_hit,
    output logic [POS_W-1:0] p1_x,
    output logic [POS_W-1:0] p2_x,
    output logic             p1_kb_active,
    output logic             p2_kb_active,
    output logic             p1_at_wall,
    output logic             p2_at_wall,
    output logic             contact
);

    // Two spare bits keep every intermediate sum/difference from wrapping.
    localparam int c_SW = POS_W + 2;
    localparam int c_CW = $clog2(KB_FRAMES + 1);

    typedef logic signed [c_SW-1:0] pos_t;

    localparam pos_t            c_X_MIN   = pos_t'(CHAR_W);
    localparam pos_t            c_X_MAX   = pos_t'(MAP_W - CHAR_W);
    localparam pos_t            c_FWD     = pos_t'(FWD_STEP);
    localparam pos_t            c_BWD     = pos_t'(BWD_STEP);
    localparam pos_t            c_KB      = pos_t'(KB_STEP);
    localparam pos_t            c_SEP     = pos_t'(MIN_SEP);
    localparam logic [c_CW-1:0] c_KB_LOAD = c_CW'(KB_FRAMES);
    localparam logic [c_CW-1:0] c_KB_LAST = c_CW'(1);

    typedef enum logic [0:0] {
        ST_MOVE = 1'b0,
        ST_KB   = 1'b1
    } kb_state_t;

    kb_state_t         r_p1_st, r_p2_st, w_p1_st_nxt, w_p2_st_nxt;
    logic [c_CW-1:0]   r_p1_cnt, r_p2_cnt, w_p1_cnt_nxt, w_p2_cnt_nxt;
    logic              r_p1_pend, r_p2_pend;
    logic [POS_W-1:0]  r_p1_x, r_p2_x;

    logic              w_p1_hit, w_p2_hit;
    pos_t              w_p1_step, w_p2_step;
    pos_t              w_x1, w_x2, w_c1, w_c2, w_n1, w_n2, w_f1, w_f2;

    // A hit seen between ticks is remembered and acted on at the next tick.
    assign w_p1_hit = p1_hit | r_p1_pend;
    assign w_p2_hit = p2_hit | r_p2_pend;

    // Per-player next state and displacement. P1 forward is +x, P2 forward
    // is -x; knockback always pushes a player toward its own wall.
    always_comb begin
        w_p1_st_nxt  = r_p1_st;
        w_p1_cnt_nxt = r_p1_cnt;
        w_p1_step    = '0;
        case (r_p1_st)
            ST_MOVE: begin
                if (w_p1_hit) begin
                    w_p1_st_nxt  = ST_KB;
                    w_p1_cnt_nxt = c_KB_LOAD;
                end else if (p1_state == 4'd1) begin
                    w_p1_step = c_FWD;
                end else if (p1_state == 4'd2) begin
                    w_p1_step = -c_BWD;
                end
            end
            default: begin
                w_p1_step = -c_KB;
                if (w_p1_hit) begin
                    w_p1_cnt_nxt = c_KB_LOAD;
                end else begin
                    w_p1_cnt_nxt = r_p1_cnt - c_KB_LAST;
                    if (r_p1_cnt == c_KB_LAST) begin
                        w_p1_st_nxt = ST_MOVE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_p2_st_nxt  = r_p2_st;
        w_p2_cnt_nxt = r_p2_cnt;
        w_p2_step    = '0;
        case (r_p2_st)
            ST_MOVE: begin
                if (w_p2_hit) begin
                    w_p2_st_nxt  = ST_KB;
                    w_p2_cnt_nxt = c_KB_LOAD;
                end else if (p2_state == 4'd1) begin
                    w_p2_step = -c_FWD;
                end else if (p2_state == 4'd2) begin
                    w_p2_step = c_BWD;
                end
            end
            default: begin
                w_p2_step = c_KB;
                if (w_p2_hit) begin
                    w_p2_cnt_nxt = c_KB_LOAD;
                end else begin
                    w_p2_cnt_nxt = r_p2_cnt - c_KB_LAST;
                    if (r_p2_cnt == c_KB_LAST) begin
                        w_p2_st_nxt = ST_MOVE;
                    end
                end
            end
        endcase
    end

    // Candidate positions, clamped exactly onto the wall limits, then the
    // separation rule: only a move that closes the gap is cancelled.
    always_comb begin
        w_x1 = pos_t'({2'b00, r_p1_x});
        w_x2 = pos_t'({2'b00, r_p2_x});
        w_c1 = w_x1 + w_p1_step;
        w_c2 = w_x2 + w_p2_step;
        w_n1 = (w_c1 < c_X_MIN) ? c_X_MIN : ((w_c1 > c_X_MAX) ? c_X_MAX : w_c1);
        w_n2 = (w_c2 < c_X_MIN) ? c_X_MIN : ((w_c2 > c_X_MAX) ? c_X_MAX : w_c2);
        w_f1 = w_n1;
        w_f2 = w_n2;
        if ((w_n2 - w_n1) < c_SEP) begin
            w_f1 = (w_n1 > w_x1) ? w_x1 : w_n1;
            w_f2 = (w_n2 < w_x2) ? w_x2 : w_n2;
            if ((w_f2 - w_f1) < c_SEP) begin
                w_f1 = w_x1;
                w_f2 = w_x2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_p1_x    <= POS_W'(CHAR_W);
            r_p2_x    <= POS_W'(MAP_W - CHAR_W);
            r_p1_st   <= ST_MOVE;
            r_p2_st   <= ST_MOVE;
            r_p1_cnt  <= '0;
            r_p2_cnt  <= '0;
            r_p1_pend <= 1'b0;
            r_p2_pend <= 1'b0;
        end else if (frame_tick) begin
            r_p1_x    <= w_f1[POS_W-1:0];
            r_p2_x    <= w_f2[POS_W-1:0];
            r_p1_st   <= w_p1_st_nxt;
            r_p2_st   <= w_p2_st_nxt;
            r_p1_cnt  <= w_p1_cnt_nxt;
            r_p2_cnt  <= w_p2_cnt_nxt;
            r_p1_pend <= 1'b0;
            r_p2_pend <= 1'b0;
        end else begin
            r_p1_pend <= r_p1_pend | p1_hit;
            r_p2_pend <= r_p2_pend | p2_hit;
        end
    end

    // Final positions are always inside the walls, so the guard bits are 0.
    logic w_unused_guard;
    assign w_unused_guard = |{w_f1[c_SW-1:POS_W], w_f2[c_SW-1:POS_W]};

    assign p1_x         = r_p1_x;
    assign p2_x         = r_p2_x;
    assign p1_kb_active = (r_p1_st == ST_KB);
    assign p2_kb_active = (r_p2_st == ST_KB);
    assign p1_at_wall   = (w_x1 == c_X_MIN);
    assign p2_at_wall   = (w_x2 == c_X_MAX);
    assign contact      = ((w_x2 - w_x1) == c_SEP);

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_player_motion_ctrl
// Description : Self-checking bench for player_motion_ctrl: directed
//               scenarios plus a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_player_motion_ctrl;

    localparam int XMIN = 64;
    localparam int XMAX = 576;
    localparam int FWD  = 3;
    localparam int BWD  = 2;
    localparam int KBS  = 4;
    localparam int KBF  = 8;
    localparam int SEP  = 128;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] p1_state = 4'd0;
    logic [3:0] p2_state = 4'd0;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic [9:0] p1_x, p2_x;
    logic       p1_kb_active, p2_kb_active, p1_at_wall, p2_at_wall, contact;

    int errors = 0;
    int checks = 0;

    // Behavioural model: positions plus remaining knockback ticks (0 = none).
    int m_x1, m_x2, m_kb1, m_kb2;
    bit m_pd1, m_pd2;

    player_motion_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .p1_state     (p1_state),
        .p2_state     (p2_state),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .p1_x         (p1_x),
        .p2_x         (p2_x),
        .p1_kb_active (p1_kb_active),
        .p2_kb_active (p2_kb_active),
        .p1_at_wall   (p1_at_wall),
        .p2_at_wall   (p2_at_wall),
        .contact      (contact)
    );

    always #5 clk = ~clk;

    function automatic int clampx(input int v);
        if (v < XMIN) return XMIN;
        if (v > XMAX) return XMAX;
        return v;
    endfunction

    task automatic model_update(input bit rn, input bit tk, input int s1, input int s2,
                                input bit h1, input bit h2);
        int d1, d2, n1, n2, a1, a2;
        bit hh1, hh2;
        if (!rn) begin
            m_x1 = XMIN; m_x2 = XMAX; m_kb1 = 0; m_kb2 = 0; m_pd1 = 0; m_pd2 = 0;
        end else if (tk) begin
            hh1 = h1 | m_pd1; hh2 = h2 | m_pd2;
            m_pd1 = 0; m_pd2 = 0;
            if (m_kb1 > 0) begin d1 = -KBS; m_kb1 = hh1 ? KBF : m_kb1 - 1; end
            else if (hh1) begin d1 = 0; m_kb1 = KBF; end
            else d1 = (s1 == 1) ? FWD : ((s1 == 2) ? -BWD : 0);
            if (m_kb2 > 0) begin d2 = KBS; m_kb2 = hh2 ? KBF : m_kb2 - 1; end
            else if (hh2) begin d2 = 0; m_kb2 = KBF; end
            else d2 = (s2 == 1) ? -FWD : ((s2 == 2) ? BWD : 0);
            n1 = clampx(m_x1 + d1);
            n2 = clampx(m_x2 + d2);
            if (n2 - n1 < SEP) begin
                a1 = (n1 > m_x1) ? m_x1 : n1;
                a2 = (n2 < m_x2) ? m_x2 : n2;
                if (a2 - a1 < SEP) begin a1 = m_x1; a2 = m_x2; end
                n1 = a1; n2 = a2;
            end
            m_x1 = n1; m_x2 = n2;
        end else begin
            m_pd1 = m_pd1 | h1; m_pd2 = m_pd2 | h2;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
    task automatic clk_step(input bit rn, input bit tk, input int s1, input int s2,
                            input bit h1, input bit h2);
        reset_n = rn; frame_tick = tk; p1_state = 4'(s1); p2_state = 4'(s2);
        p1_hit = h1; p2_hit = h2;
        @(posedge clk);
        model_update(rn, tk, s1, s2, h1, h2);
        #1;
        frame_tick = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
    endtask

    task automatic do_reset();
        clk_step(0, 0, 0, 0, 0, 0);
        clk_step(0, 0, 0, 0, 0, 0);
    endtask

    // Walk one player to an exact position using ticks (other player holds).
    task automatic move_to(input int who, input int target);
        int d, up_st, dn_st, up, dn;
        up_st = (who == 1) ? 1 : 2; dn_st = (who == 1) ? 2 : 1;
        up    = (who == 1) ? FWD : BWD; dn = (who == 1) ? BWD : FWD;
        for (int i = 0; i < 500; i++) begin
            d = target - ((who == 1) ? m_x1 : m_x2);
            if (d == 0) break;
            if (d >= up || (d > 0 && d > -dn)) begin
                if (who == 1) clk_step(1, 1, up_st, 0, 0, 0); else clk_step(1, 1, 0, up_st, 0, 0);
            end else begin
                if (who == 1) clk_step(1, 1, dn_st, 0, 0, 0); else clk_step(1, 1, 0, dn_st, 0, 0);
            end
        end
        checks++;
        if (int'((who == 1) ? p1_x : p2_x) !== target) begin
            errors++;
            $display("FAIL move_to p%0d: got %0d want %0d", who, (who == 1) ? p1_x : p2_x, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (p1_x !== 10'd64)       begin errors++; $display("FAIL reset_p1_x: got %0d want 64", p1_x); end
        if (p2_x !== 10'd576)      begin errors++; $display("FAIL reset_p2_x: got %0d want 576", p2_x); end
        if (p1_kb_active !== 1'b0 || p2_kb_active !== 1'b0)
            begin errors++; $display("FAIL reset_kb: got %b%b want 00", p1_kb_active, p2_kb_active); end
        if (p1_at_wall !== 1'b1)   begin errors++; $display("FAIL reset_p1_wall: got %b want 1", p1_at_wall); end
        if (p2_at_wall !== 1'b1)   begin errors++; $display("FAIL reset_p2_wall: got %b want 1", p2_at_wall); end
        if (contact !== 1'b0)      begin errors++; $display("FAIL reset_contact: got %b want 0", contact); end
    endtask

    task automatic test_no_tick();
        for (int i = 0; i < 100; i++) clk_step(1, 0, 1, 1, 0, 0);
        checks += 2;
        if (p1_x !== 10'd64)  begin errors++; $display("FAIL no_tick_p1: got %0d want 64", p1_x); end
        if (p2_x !== 10'd576) begin errors++; $display("FAIL no_tick_p2: got %0d want 576", p2_x); end
    endtask

    task automatic test_wall_clamp();
        do_reset();
        move_to(1, 65);
        clk_step(1, 1, 2, 0, 0, 0);
        checks += 2;
        if (p1_x !== 10'd64)    begin errors++; $display("FAIL wall_clamp_x: got %0d want 64", p1_x); end
        if (p1_at_wall !== 1'b1) begin errors++; $display("FAIL wall_clamp_flag: got %b want 1", p1_at_wall); end
        // P2 backward at its wall clamps too.
        clk_step(1, 1, 0, 2, 0, 0);
        checks++;
        if (p2_x !== 10'd576)   begin errors++; $display("FAIL wall_clamp_p2: got %0d want 576", p2_x); end
    endtask

    task automatic test_contact();
        do_reset();
        move_to(1, 300);
        move_to(2, 430);
        clk_step(1, 1, 1, 1, 0, 0);
        checks += 3;
        if (p1_x !== 10'd300) begin errors++; $display("FAIL contact_hold_p1: got %0d want 300", p1_x); end
        if (p2_x !== 10'd430) begin errors++; $display("FAIL contact_hold_p2: got %0d want 430", p2_x); end
        if (contact !== 1'b0) begin errors++; $display("FAIL contact_hold_flag: got %b want 0", contact); end
        move_to(2, 431);
        clk_step(1, 1, 1, 0, 0, 0);
        checks += 2;
        if (p1_x !== 10'd303) begin errors++; $display("FAIL contact_p1: got %0d want 303", p1_x); end
        if (contact !== 1'b1) begin errors++; $display("FAIL contact_flag: got %b want 1", contact); end
    endtask

    task automatic test_knockback();
        do_reset();
        move_to(1, 300);
        clk_step(1, 1, 1, 0, 1, 0);
        checks += 2;
        if (p1_x !== 10'd300)       begin errors++; $display("FAIL kb_entry_x: got %0d want 300", p1_x); end
        if (p1_kb_active !== 1'b1)  begin errors++; $display("FAIL kb_entry_flag: got %b want 1", p1_kb_active); end
        for (int i = 1; i <= KBF; i++) begin
            clk_step(1, 1, 1, 0, 0, 0);
            checks++;
            if (p1_kb_active !== (i < KBF))
                begin errors++; $display("FAIL kb_flag_t%0d: got %b want %b", i, p1_kb_active, i < KBF); end
        end
        checks++;
        if (p1_x !== 10'd268) begin errors++; $display("FAIL kb_end_x: got %0d want 268", p1_x); end
        // Re-hit on knockback tick 4.
        move_to(1, 300);
        clk_step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) clk_step(1, 1, 0, 0, 0, 0);
        clk_step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < KBF; i++) clk_step(1, 1, 0, 0, 0, 0);
        checks += 2;
        if (p1_x !== 10'd252)      begin errors++; $display("FAIL kb_rehit_x: got %0d want 252", p1_x); end
        if (p1_kb_active !== 1'b0) begin errors++; $display("FAIL kb_rehit_flag: got %b want 0", p1_kb_active); end
        // Hit between ticks is applied at the next tick.
        clk_step(1, 0, 0, 0, 0, 1);
        clk_step(1, 0, 0, 0, 0, 0);
        checks++;
        if (p2_kb_active !== 1'b0) begin errors++; $display("FAIL kb_pend_early: got %b want 0", p2_kb_active); end
        clk_step(1, 1, 0, 0, 0, 0);
        checks++;
        if (p2_kb_active !== 1'b1) begin errors++; $display("FAIL kb_pend_apply: got %b want 1", p2_kb_active); end
    endtask

    task automatic test_reset_mid_kb();
        do_reset();
        move_to(1, 300);
        clk_step(1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) clk_step(1, 1, 0, 0, 0, 0);
        clk_step(1, 0, 0, 0, 1, 1);   // leaves hits pending
        clk_step(0, 1, 1, 1, 1, 1);   // reset wins over tick and hits
        checks += 3;
        if (p1_x !== 10'd64 || p2_x !== 10'd576)
            begin errors++; $display("FAIL mid_kb_pos: got %0d/%0d want 64/576", p1_x, p2_x); end
        if (p1_kb_active !== 1'b0 || p2_kb_active !== 1'b0)
            begin errors++; $display("FAIL mid_kb_flag: got %b%b want 00", p1_kb_active, p2_kb_active); end
        clk_step(1, 1, 0, 0, 0, 0);
        if (p1_kb_active !== 1'b0 || p2_kb_active !== 1'b0)
            begin errors++; $display("FAIL mid_kb_pending: got %b%b want 00", p1_kb_active, p2_kb_active); end
    endtask

    task automatic test_random();
        bit rn, tk, h1, h2;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rn = ($urandom_range(0, 599) != 0);
            tk = ($urandom_range(0, 2) == 0);
            h1 = ($urandom_range(0, 39) == 0);
            h2 = ($urandom_range(0, 39) == 0);
            clk_step(rn, tk, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), h1, h2);
            checks++;
            if (int'(p1_x) !== m_x1 || int'(p2_x) !== m_x2 ||
                p1_kb_active !== (m_kb1 > 0) || p2_kb_active !== (m_kb2 > 0) ||
                p1_at_wall !== (m_x1 == XMIN) || p2_at_wall !== (m_x2 == XMAX) ||
                contact !== (m_x2 - m_x1 == SEP)) begin
                errors++;
                $display("FAIL random_c%0d: got x=%0d/%0d kb=%b%b wall=%b%b ct=%b want x=%0d/%0d kb=%b%b wall=%b%b ct=%b",
                         i, p1_x, p2_x, p1_kb_active, p2_kb_active, p1_at_wall, p2_at_wall, contact,
                         m_x1, m_x2, m_kb1 > 0, m_kb2 > 0, m_x1 == XMIN, m_x2 == XMAX, m_x2 - m_x1 == SEP);
            end
        end
    endtask

    initial begin
        m_x1 = XMIN; m_x2 = XMAX; m_kb1 = 0; m_kb2 = 0; m_pd1 = 0; m_pd2 = 0;
        test_reset();
        test_no_tick();
        test_wall_clamp();
        test_contact();
        test_knockback();
        test_reset_mid_kb();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
